word_match_scheduler: RTL

//  Sequences word-by-word pattern matching over the SPI byte stream. Collects one word
//  (chars until an end-of-word beat) into a local buffer, then time-shares one masked
//  8-bit comparator across the programmed pattern (characters/masks/word_size) and emits
//  a result id per word on M_AXIS, back to the SPI controller's result slots.

---
 rtl/word_match_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/word_match_scheduler.sv
// Word-by-word pattern match scheduler: collects one word from the byte stream, then
// time-shares a single masked 8-bit comparator across the latched pattern and emits a result id.
module word_match_scheduler #(
  parameter int MAX_CHARS = 8,
  parameter int ID_BITS   = 7
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tuser,
  output logic                   s_axis_tready,
  input  logic [7:0]             word_size,
  input  logic [7:0]             result_mask,
  input  logic [MAX_CHARS*8-1:0] characters,
  input  logic [MAX_CHARS*8-1:0] masks,
  output logic                   m_axis_tvalid,
  output logic [7:0]             m_axis_tdata,
  output logic                   busy
);

  localparam int LEN_W = $clog2(MAX_CHARS + 1);
  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [7:0]       MAX_B   = 8'(MAX_CHARS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHARS);

  typedef enum logic [1:0] {COLLECT, COMPARE, EMIT} state_t;

  state_t state, state_next;

  logic [7:0]             word_buf [MAX_CHARS];
  logic [LEN_W-1:0]       len;
  logic                   ovf;
  logic [IDX_W-1:0]       cnt;
  logic                   match;
  logic [ID_BITS-1:0]     word_id;

  // Pattern configuration frozen at the end-of-word beat.
  logic [7:0]             pat_size;
  logic [1:0]             pat_rm;
  logic [MAX_CHARS*8-1:0] pat_chars;
  logic [MAX_CHARS*8-1:0] pat_masks;

  logic       beat;
  logic       word_valid;
  logic       char_ok;
  logic       match_final;
  logic       last_cmp;
  logic       miss_final;
  logic       report;
  logic [7:0] result_data;
  logic [7:0] cmp_char;
  logic [7:0] cmp_mask;
  logic       unused_rm;

  assign beat      = s_axis_tvalid && s_axis_tready;
  assign busy      = (state != COLLECT);
  assign unused_rm = ^result_mask[7:2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cmp_char    = pat_chars[{cnt, 3'b000} +: 8];
    cmp_mask    = pat_masks[{cnt, 3'b000} +: 8];
    word_valid  = (pat_size != 8'd0) && (pat_size <= MAX_B) && !ovf && (8'(len) == pat_size);
    char_ok     = ((word_buf[cnt] ^ cmp_char) & ~cmp_mask) == 8'd0;
    match_final = match && char_ok;
    last_cmp    = (8'(cnt) + 8'd1) == pat_size;
    miss_final  = !(word_valid && match_final);
    report      = (!miss_final && pat_rm[0]) || (miss_final && pat_rm[1]);
    result_data = '0;
    result_data[7] = miss_final;
    result_data[ID_BITS-1:0] = word_id;

    case (state)
      COLLECT: if (beat && s_axis_tuser) state_next = COMPARE;
      COMPARE: if (!word_valid || last_cmp) state_next = EMIT;
      EMIT:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= COLLECT;
    else        state <= state_next;
  end

  // NOTE: the word buffer is storage only; len gates its contents, so it carries no reset.
  always_ff @(posedge aclk) begin
    if (beat && !s_axis_tuser && (len < LEN_MAX))
      word_buf[len[IDX_W-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      len           <= '0;
      ovf           <= 1'b0;
      cnt           <= '0;
      match         <= 1'b0;
      word_id       <= '0;
      pat_size      <= '0;
      pat_rm        <= '0;
      pat_chars     <= '0;
      pat_masks     <= '0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      s_axis_tready <= (state_next == COLLECT);
      m_axis_tvalid <= 1'b0;
      case (state)
        COLLECT: begin
          if (beat) begin
            if (s_axis_tuser) begin
              pat_size  <= word_size;
              pat_rm    <= result_mask[1:0];
              pat_chars <= characters;
              pat_masks <= masks;
              cnt       <= '0;
              match     <= 1'b1;
            end else if (len < LEN_MAX) begin
              len <= len + LEN_W'(1);
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        COMPARE: begin
          cnt   <= cnt + IDX_W'(1);
          match <= match_final;
          if (state_next == EMIT) begin
            m_axis_tvalid <= report;
            m_axis_tdata  <= result_data;
          end
        end
        EMIT: begin
          word_id <= word_id + ID_BITS'(1);
          len     <= '0;
          ovf     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
